// File: rtl/data_cache_ctrl.sv
// Direct-mapped L1 data cache controller with line-wide memory port.
// Write-back or write-through (both write-allocate), req/ack miss FSM.
module data_cache_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int LINES          = 16,
  parameter int WRITE_BACK     = 1,
  parameter int CNT_W          = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_W-1:0]                address,
  input  logic [WORD_W-1:0]                data,
  input  logic                             dataRead,
  input  logic                             dataWrite,
  output logic [WORD_W-1:0]                outData,
  output logic                             hit,
  output logic                             stall,
  output logic                             memReq,
  output logic                             memWe,
  output logic [ADDR_W-1:0]                memAddr,
  output logic [WORD_W*WORDS_PER_LINE-1:0] memWData,
  input  logic [WORD_W*WORDS_PER_LINE-1:0] memRData,
  input  logic                             memAck,
  output logic [CNT_W-1:0]                 hitCount,
  output logic [CNT_W-1:0]                 missCount
);

  localparam int WSEL_W = $clog2(WORDS_PER_LINE);
  localparam int OFF_W  = WSEL_W + 2;
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;

  typedef enum logic [1:0] {
    IDLE, EVICT, FILL, WT_WRITE
  } state_t;

  state_t state;

  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [LINE_W-1:0] lines [LINES];

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [WSEL_W-1:0] wsel;
  logic              unused_bits;
  logic              req;
  logic              tag_eq;
  logic              miss;
  logic              wr_hit;
  logic              ack_ok;
  logic [LINE_W-1:0] cur_line;
  logic [LINE_W-1:0] upd_line;

  assign tag         = address[ADDR_W-1 -: TAG_W];
  assign idx         = address[OFF_W +: IDX_W];
  assign wsel        = address[2 +: WSEL_W];
  assign unused_bits = ^address[1:0];

  assign req      = dataRead | dataWrite;
  assign cur_line = lines[idx];
  assign tag_eq   = valid[idx] && (tags[idx] == tag);
  assign hit      = (state == IDLE) && req && tag_eq;
  assign stall    = (req && !hit) || (state != IDLE);
  assign miss     = (state == IDLE) && req && !tag_eq;
  assign wr_hit   = hit && dataWrite;
  assign ack_ok   = memReq && memAck;
  assign outData  = cur_line[wsel*WORD_W +: WORD_W];

  always_comb begin
    upd_line = cur_line;
    upd_line[wsel*WORD_W +: WORD_W] = data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      dirty     <= '0;
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWData  <= '0;
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      if (hit)
        hitCount <= hitCount + CNT_W'(1);
      unique case (state)
        IDLE: begin
          if (miss) begin
            missCount <= missCount + CNT_W'(1);
            if (valid[idx] && dirty[idx]) begin
              state    <= EVICT;
              memWe    <= 1'b1;
              memAddr  <= {tags[idx], idx, {OFF_W{1'b0}}};
              memWData <= cur_line;
            end else begin
              state   <= FILL;
              memWe   <= 1'b0;
              memAddr <= {tag, idx, {OFF_W{1'b0}}};
            end
          end else if (wr_hit) begin
            if (WRITE_BACK != 0) begin
              dirty[idx] <= 1'b1;
            end else begin
              state    <= WT_WRITE;
              memWe    <= 1'b1;
              memAddr  <= {tag, idx, {OFF_W{1'b0}}};
              memWData <= upd_line;
            end
          end
        end
        EVICT: begin
          if (ack_ok) begin
            state      <= FILL;
            memReq     <= 1'b0;
            memWe      <= 1'b0;
            memAddr    <= {tag, idx, {OFF_W{1'b0}}};
            dirty[idx] <= 1'b0;
          end else begin
            memReq <= 1'b1;
          end
        end
        FILL: begin
          if (ack_ok) begin
            state      <= IDLE;
            memReq     <= 1'b0;
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
          end else begin
            memReq <= 1'b1;
          end
        end
        WT_WRITE: begin
          if (ack_ok) begin
            state  <= IDLE;
            memReq <= 1'b0;
            memWe  <= 1'b0;
          end else begin
            memReq <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == FILL && ack_ok) begin
        lines[idx] <= memRData;
        tags[idx]  <= tag;
      end else if (wr_hit) begin
        lines[idx] <= upd_line;
      end
    end
  end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl: one write-back and one
// write-through instance, each with its own latency-driven memory.
module tb_data_cache_ctrl;

  localparam int LW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          a_rd, a_wr, a_hit, a_stall, a_mreq, a_mwe;
  logic          a_ack = 1'b0;
  logic [31:0]   a_addr, a_data, a_out, a_maddr, a_hc, a_mc;
  logic [LW-1:0] a_mwd;
  logic [LW-1:0] a_mrd = '0;

  logic          b_rd, b_wr, b_hit, b_stall, b_mreq, b_mwe;
  logic          b_ack = 1'b0;
  logic [31:0]   b_addr, b_data, b_out, b_maddr, b_hc, b_mc;
  logic [LW-1:0] b_mwd;
  logic [LW-1:0] b_mrd = '0;

  data_cache_ctrl #(.WRITE_BACK(1)) u_wb (
    .clk(clk), .rst(rst),
    .address(a_addr), .data(a_data),
    .dataRead(a_rd), .dataWrite(a_wr),
    .outData(a_out), .hit(a_hit), .stall(a_stall),
    .memReq(a_mreq), .memWe(a_mwe), .memAddr(a_maddr),
    .memWData(a_mwd), .memRData(a_mrd), .memAck(a_ack),
    .hitCount(a_hc), .missCount(a_mc)
  );

  data_cache_ctrl #(.WRITE_BACK(0)) u_wt (
    .clk(clk), .rst(rst),
    .address(b_addr), .data(b_data),
    .dataRead(b_rd), .dataWrite(b_wr),
    .outData(b_out), .hit(b_hit), .stall(b_stall),
    .memReq(b_mreq), .memWe(b_mwe), .memAddr(b_maddr),
    .memWData(b_mwd), .memRData(b_mrd), .memAck(b_ack),
    .hitCount(b_hc), .missCount(b_mc)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] pat(input logic [31:0] ad);
    return 32'hA500_0000 ^ ad ^ {ad[19:0], 12'h000};
  endfunction

  function automatic logic [LW-1:0] mkline(
    input logic [31:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  // Memory models: ack after *_lat cycles of memReq.
  logic [31:0]   a_mem [int];
  logic [31:0]   b_mem [int];
  int            a_lat = 3, b_lat = 2;
  int            a_cnt = 0, b_cnt = 0;
  int            a_wrs = 0, b_wrs = 0;
  logic          a_auto = 1'b1, a_force = 1'b0;
  logic [31:0]   a_lwa = '0, a_lra = '0, b_lwa = '0, b_lra = '0;
  logic [LW-1:0] a_lwd = '0, b_lwd = '0;

  always @(negedge clk) begin
    if (!a_mreq) a_cnt = 0;
    else a_cnt = a_cnt + 1;
    if (!a_auto) begin
      a_ack = a_force;
    end else if (a_mreq && a_cnt == a_lat) begin
      a_ack = 1'b1;
      if (a_mwe) begin
        a_wrs++;
        a_lwa = a_maddr;
        a_lwd = a_mwd;
        for (int w = 0; w < 4; w++)
          a_mem[int'(a_maddr) + 4*w] = a_mwd[w*32 +: 32];
      end else begin
        a_lra = a_maddr;
        for (int w = 0; w < 4; w++)
          a_mrd[w*32 +: 32] = a_mem.exists(int'(a_maddr) + 4*w) ?
            a_mem[int'(a_maddr) + 4*w] : pat(a_maddr + 32'(4*w));
      end
    end else begin
      a_ack = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!b_mreq) b_cnt = 0;
    else b_cnt = b_cnt + 1;
    if (b_mreq && b_cnt == b_lat) begin
      b_ack = 1'b1;
      if (b_mwe) begin
        b_wrs++;
        b_lwa = b_maddr;
        b_lwd = b_mwd;
        for (int w = 0; w < 4; w++)
          b_mem[int'(b_maddr) + 4*w] = b_mwd[w*32 +: 32];
      end else begin
        b_lra = b_maddr;
        for (int w = 0; w < 4; w++)
          b_mrd[w*32 +: 32] = b_mem.exists(int'(b_maddr) + 4*w) ?
            b_mem[int'(b_maddr) + 4*w] : pat(b_maddr + 32'(4*w));
      end
    end else begin
      b_ack = 1'b0;
    end
  end

  logic use_b = 1'b0;
  wire         m_hit   = use_b ? b_hit   : a_hit;
  wire         m_stall = use_b ? b_stall : a_stall;
  wire         m_req   = use_b ? b_mreq  : a_mreq;
  wire  [31:0] m_out   = use_b ? b_out   : a_out;

  task automatic chk(input string nm,
                     input logic [LW-1:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic rd, wr,
                     input logic [31:0] ad, dt);
    if (use_b) begin
      b_rd = rd; b_wr = wr; b_addr = ad; b_data = dt;
    end else begin
      a_rd = rd; a_wr = wr; a_addr = ad; a_data = dt;
    end
  endtask

  // Holds a request until it hits; counts stall and memReq cycles.
  task automatic acc(input logic rd, wr,
                     input logic [31:0] ad, dt,
                     output int st, output int rq,
                     output logic [31:0] od, output logic ok);
    st = 0; rq = 0; od = '0; ok = 1'b0;
    drv(rd, wr, ad, dt);
    for (int i = 0; i < 40; i++) begin
      #1;
      if (m_stall) st++;
      if (m_hit) begin
        od = m_out;
        ok = 1'b1;
        break;
      end
      if (m_req) rq++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    drv(1'b0, 1'b0, ad, dt);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] ad;
    logic [31:0] dt;
    logic        eh;
    logic [31:0] eo;
  } vec_t;

  vec_t tbl [20];

  initial begin
    int st, rq, n, sum, hc_exp;
    logic [31:0] od, ad;
    logic ok;

    for (int i = 0; i < 16; i++) begin
      ad = 32'h1000 + 32'(i*16) + 32'((i % 4) * 4);
      tbl[i] = '{1'b1, 1'b0, ad, 32'h0, 1'b1, pat(ad)};
    end
    tbl[16] = '{1'b0, 1'b1, 32'h1008, 32'hCAFE_0001, 1'b1, 32'h0};
    tbl[17] = '{1'b1, 1'b0, 32'h1008, 32'h0, 1'b1, 32'hCAFE_0001};
    tbl[18] = '{1'b1, 1'b1, 32'h1054, 32'h55AA_55AA, 1'b1, 32'h0};
    tbl[19] = '{1'b1, 1'b0, 32'h1054, 32'h0, 1'b1, 32'h55AA_55AA};

    a_rd = 0; a_wr = 0; a_addr = 0; a_data = 0;
    b_rd = 0; b_wr = 0; b_addr = 0; b_data = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_memReq", a_mreq, 0);
    chk("rst_memWe", a_mwe, 0);
    chk("rst_memAddr", a_maddr, 0);
    chk("rst_memWData", a_mwd, 0);
    chk("rst_hitCount", a_hc, 0);
    chk("rst_missCount", a_mc, 0);
    chk("rst_stall", a_stall, 0);
    chk("rst_wt_memReq", b_mreq, 0);

    // Cold load
    acc(1, 0, 32'h100, 0, st, rq, od, ok);
    chk("cold_ok", ok, 1);
    chk("cold_stall", st, 5);
    chk("cold_req", rq, 3);
    chk("cold_data", od, pat(32'h100));
    chk("cold_rdaddr", a_lra, 32'h100);
    chk("cold_writes", a_wrs, 0);
    chk("cold_hc", a_hc, 1);
    chk("cold_mc", a_mc, 1);

    // Write-back store hit, then conflicting load evicts it
    acc(0, 1, 32'h104, 32'hDEAD_BEEF, st, rq, od, ok);
    chk("wbst_ok", ok, 1);
    chk("wbst_stall", st, 0);
    chk("wbst_memReq", a_mreq, 0);
    acc(1, 0, 32'h504, 0, st, rq, od, ok);
    chk("evict_stall", st, 9);
    chk("evict_req", rq, 6);
    chk("evict_writes", a_wrs, 1);
    chk("evict_waddr", a_lwa, 32'h100);
    chk("evict_wdata", a_lwd, mkline(pat(32'h100), 32'hDEAD_BEEF,
                                     pat(32'h108), pat(32'h10C)));
    chk("evict_rdaddr", a_lra, 32'h500);
    chk("evict_data", od, pat(32'h504));
    chk("evict_mc", a_mc, 2);
    chk("evict_hc", a_hc, 3);

    acc(1, 0, 32'h104, 0, st, rq, od, ok);
    chk("reload_stall", st, 5);
    chk("reload_data", od, 32'hDEAD_BEEF);
    chk("reload_writes", a_wrs, 1);

    // Read and write together act as a store
    acc(1, 1, 32'h108, 32'h0BAD_F00D, st, rq, od, ok);
    chk("rw_stall", st, 0);
    chk("rw_req", rq, 0);
    acc(1, 0, 32'h108, 0, st, rq, od, ok);
    chk("rw_readback", od, 32'h0BAD_F00D);
    acc(1, 0, 32'h508, 0, st, rq, od, ok);
    chk("rw_dirty_stall", st, 9);
    chk("rw_writes", a_wrs, 2);
    chk("rw_wdata", a_lwd, mkline(pat(32'h100), 32'hDEAD_BEEF,
                                  32'h0BAD_F00D, pat(32'h10C)));
    chk("rw_mc", a_mc, 4);
    chk("rw_hc", a_hc, 7);

    // Reset while a fill is outstanding
    a_auto = 1'b0;
    drv(1, 0, 32'h200, 0);
    for (int i = 0; i < 20; i++) begin
      if (a_mreq) break;
      @(posedge clk); #1;
    end
    chk("rf_req_seen", a_mreq, 1);
    chk("rf_we", a_mwe, 0);
    chk("rf_addr", a_maddr, 32'h200);
    rst = 1'b1;
    drv(0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rf_memReq", a_mreq, 0);
    chk("rf_stall", a_stall, 0);
    chk("rf_hc", a_hc, 0);
    chk("rf_mc", a_mc, 0);
    chk("rf_memAddr", a_maddr, 0);
    a_force = 1'b1;
    @(posedge clk); #1;
    a_force = 1'b0;
    @(posedge clk); #1;
    chk("rf_lateack_req", a_mreq, 0);
    chk("rf_lateack_stall", a_stall, 0);
    a_auto = 1'b1;
    acc(1, 0, 32'h200, 0, st, rq, od, ok);
    chk("rf_remiss_stall", st, 5);
    chk("rf_remiss_data", od, pat(32'h200));
    chk("rf_remiss_mc", a_mc, 1);

    // First sweep: every index misses
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      acc(tbl[i].rd, tbl[i].wr, tbl[i].ad, 0, st, rq, od, ok);
      sum += st;
      chk($sformatf("sweep1_data%0d", i), od, tbl[i].eo);
    end
    chk("sweep1_stalls", sum, 80);
    chk("sweep1_mc", a_mc, 17);
    chk("sweep1_hc", a_hc, 17);

    // Second sweep plus stores, one vector per cycle
    hc_exp = 17;
    for (int k = 0; k < 20; k++) begin
      drv(tbl[k].rd, tbl[k].wr, tbl[k].ad, tbl[k].dt);
      #1;
      chk($sformatf("vec%0d_hit", k), a_hit, tbl[k].eh);
      chk($sformatf("vec%0d_stall", k), a_stall, !tbl[k].eh);
      if (tbl[k].rd && !tbl[k].wr)
        chk($sformatf("vec%0d_data", k), a_out, tbl[k].eo);
      chk($sformatf("vec%0d_hc", k), a_hc, hc_exp);
      if (tbl[k].eh) hc_exp++;
      @(posedge clk); #1;
    end
    drv(0, 0, 0, 0);
    chk("sweep2_mc", a_mc, 17);
    chk("sweep2_hc", a_hc, 37);
    chk("sweep2_memReq", a_mreq, 0);

    // Write-through instance
    use_b = 1'b1;
    acc(1, 0, 32'h300, 0, st, rq, od, ok);
    chk("wt_cold_stall", st, 4);
    chk("wt_cold_req", rq, 2);
    chk("wt_cold_data", od, pat(32'h300));
    acc(0, 1, 32'h304, 32'h1234_5678, st, rq, od, ok);
    chk("wt_st_hitstall", st, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!b_stall) break;
      n++;
      @(posedge clk); #1;
    end
    chk("wt_st_stall", n, 3);
    chk("wt_st_memReq", b_mreq, 0);
    chk("wt_st_writes", b_wrs, 1);
    chk("wt_st_waddr", b_lwa, 32'h300);
    chk("wt_st_wdata", b_lwd, mkline(pat(32'h300), 32'h1234_5678,
                                     pat(32'h308), pat(32'h30C)));
    acc(1, 0, 32'h704, 0, st, rq, od, ok);
    chk("wt_conf_stall", st, 4);
    chk("wt_conf_req", rq, 2);
    chk("wt_conf_writes", b_wrs, 1);
    chk("wt_conf_rdaddr", b_lra, 32'h700);
    chk("wt_conf_data", od, pat(32'h704));
    acc(1, 0, 32'h304, 0, st, rq, od, ok);
    chk("wt_reload_data", od, 32'h1234_5678);
    chk("wt_mc", b_mc, 3);
    chk("wt_hc", b_hc, 4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/data_cache_ctrl.md
Name: data_cache_ctrl

Overview:
- Parametrised direct-mapped L1 data cache controller between the datapath load/store port and the line-wide data memory.
- Successor to the fixed 128-bit-line lookup:
  - configurable line count and words per line;
  - explicit miss FSM with a req/ack memory handshake;
  - selectable write-back or write-through policy;
  - CPU stall output;
  - hit/miss performance counters.

Parameters:
- ADDR_W, 32, byte address width
- WORD_W, 32, CPU data word width
- WORDS_PER_LINE, 4, words per cache line (power of two, ≥2)
- LINES, 16, number of cache lines (power of two)
- WRITE_BACK, 1, 1 = write-back with write-allocate; 0 = write-through with write-allocate
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- address  in  ADDR_W  CPU byte address (word-aligned; bits [1:0] ignored)
- data  in  WORD_W  CPU store data
- dataRead  in  1  load request
- dataWrite  in  1  store request
- outData  out  WORD_W  load data; valid when hit=1 and dataRead=1
- hit  out  1  current request hits in IDLE
- stall  out  1  CPU must hold address/data/controls stable
- memReq  out  1  memory request
- memWe  out  1  1 = line write, 0 = line read
- memAddr  out  ADDR_W  line-aligned memory address (offset bits zero)
- memWData  out  WORD_W*WORDS_PER_LINE  line write data
- memRData  in  WORD_W*WORDS_PER_LINE  line read data, valid with memAck
- memAck  in  1  one-cycle completion pulse
- hitCount  out  CNT_W  completed hit accesses
- missCount  out  CNT_W  misses detected

Behaviour:
- Address split:
  - offset = log2(WORDS_PER_LINE)+2 LSBs;
  - index = next log2(LINES) bits;
  - tag = remainder.
- Storage: per-line arrays of valid, dirty, tag and data.
- Request priority: req = dataRead | dataWrite; when both are asserted, the access is a store and outData is don't-care.
- hit (combinational) = state==IDLE & req & valid[index] & tag match.
- stall (combinational) = req & !hit, OR state != IDLE.
- Read hit: outData = selected word, combinational, same cycle; zero-latency.
- Write hit, WRITE_BACK=1:
  - word written at the clock edge;
  - dirty set;
  - no memory traffic.
- Write hit, WRITE_BACK=0:
  - word written into the line;
  - FSM enters WT_WRITE, which issues memWe=1 with the full updated line;
  - stall held until memAck.
- FSM states: IDLE, EVICT, FILL, WT_WRITE.
  - IDLE → EVICT on a miss with a valid and dirty victim; memAddr = {victim tag, index, 0}; memWData = victim line.
  - IDLE → FILL on a miss with a clean or invalid victim.
  - EVICT → FILL on memAck; dirty cleared.
  - FILL → IDLE on memAck:
    - line loaded from memRData;
    - tag written, valid=1, dirty=0.
    - The held request then hits on the following cycle, so miss latency = memory latency + 1 cycle (+ eviction).
  - WT_WRITE → IDLE on memAck.
- Handshake:
  - memReq is registered; it rises the cycle after entering EVICT/FILL/WT_WRITE.
  - memReq, memWe, memAddr and memWData stay stable until memAck is sampled high.
  - memReq is 0 in the cycle after memAck.
  - memAck while memReq=0 is ignored.
- Counters:
  - missCount increments once per miss, on the IDLE→EVICT/FILL transition.
  - hitCount increments on each cycle with hit=1.
  - Both wrap modulo 2^CNT_W.
- Reset, including mid-operation:
  - all valid/dirty bits cleared; state=IDLE;
  - memReq=0, memWe=0, memAddr=0, memWData=0;
  - hitCount=0, missCount=0;
  - an in-flight transfer is abandoned and a later memAck is ignored;
  - outData is don't-care while hit=0.
- Data arrays are not reset.

Test Plan:
- Reset, then load 0x100 with memory latency 3 → missCount=1; memReq=1, memWe=0, memAddr=0x100 for 3 cycles; stall high for 5 cycles total; then hit=1 with outData = word 0 of the returned line; hitCount=1.
- With WRITE_BACK=1: store 0xDEADBEEF to 0x104 (hit), then load 0x504 (same index, different tag) → EVICT writes a line with word1=0xDEADBEEF to memAddr 0x100; then FILL reads 0x500; final outData = memory word at 0x504.
- With WRITE_BACK=0: store 0x12345678 to a cached address → WT_WRITE issues memWe=1 with the updated line; stall is released the cycle after memAck; dirty never set (a later conflicting miss goes straight to FILL).
- Assert rst during FILL while memReq=1 → next cycle memReq=0, stall=0, counters 0; memAck pulsed afterwards is ignored; re-access misses again.
- Back-to-back loads across all LINES indices, then the same sweep again → first sweep missCount=LINES; second sweep all hits, missCount unchanged; hitCount increments each cycle.
- dataRead and dataWrite both high on a hit → treated as a store: word updated, dirty set (WRITE_BACK=1), no memory request.
